// File: rtl/rs_age_picker.sv
// rs_age_picker: reservation-station allocator and oldest-ready issue picker.
// Tracks the valid entries and an age matrix (age[i][j] = 1 means i is older
// than j). Each cycle the oldest entry whose sources are all ready is offered
// to the execution port.
// Handshake: issue_vld_rs1 offers issue_id_rs1; the entry is consumed only in
// a cycle where issue_vld_rs1 and issue_gnt_rs1 are both high. Without a grant
// the pick is recomputed the next cycle.
// Optional macro RS_PICK_WDOG_EN adds a no-progress watchdog driving wdog_hang.
module rs_age_picker #(
    parameter int NUM_ENTS    = 8,
    parameter int NUM_SRCS    = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_rs0,
    output logic                           alloc_rdy_rs0,
    output logic [$clog2(NUM_ENTS)-1:0]    alloc_id_rs0,
    output logic [NUM_ENTS-1:0]            e_alloc_rs0,
    input  logic [NUM_ENTS*NUM_SRCS-1:0]   src_ready_rs1,
    output logic                           issue_vld_rs1,
    output logic [$clog2(NUM_ENTS)-1:0]    issue_id_rs1,
    input  logic                           issue_gnt_rs1,
    input  logic                           flush,
    output logic [NUM_ENTS-1:0]            e_dealloc,
    output logic [$clog2(NUM_ENTS):0]      occupancy,
    output logic                           wdog_hang
);
    localparam int IW = $clog2(NUM_ENTS);
    localparam int OW = $clog2(NUM_ENTS) + 1;

    logic [NUM_ENTS-1:0] valid_q, valid_d;
    logic [NUM_ENTS-1:0] age_q [NUM_ENTS];
    logic [NUM_ENTS-1:0] age_d [NUM_ENTS];
    logic [NUM_ENTS-1:0] elig, sel;
    logic                alloc_fire, issue_fire;

    // Allocation: lowest free entry, gated by flush and reset.
    always_comb begin
        alloc_id_rs0 = '0;
        for (int i = NUM_ENTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_id_rs0 = IW'(i);
        end
        alloc_rdy_rs0 = ~&valid_q;
        alloc_fire    = alloc_rs0 & alloc_rdy_rs0 & ~flush & ~reset;
        e_alloc_rs0   = '0;
        if (alloc_fire) e_alloc_rs0[alloc_id_rs0] = 1'b1;
    end

    // Pick: an eligible entry is selected when no eligible entry is older.
    always_comb begin
        elig         = '0;
        sel          = '0;
        issue_id_rs1 = '0;
        for (int e = 0; e < NUM_ENTS; e++) begin
            elig[e] = valid_q[e] & (&src_ready_rs1[e*NUM_SRCS +: NUM_SRCS]);
        end
        for (int e = 0; e < NUM_ENTS; e++) begin
            sel[e] = elig[e];
            for (int j = 0; j < NUM_ENTS; j++) begin
                if (j != e && elig[j] && age_q[j][e]) sel[e] = 1'b0;
            end
        end
        for (int e = NUM_ENTS - 1; e >= 0; e--) begin
            if (sel[e]) issue_id_rs1 = IW'(e);
        end
        issue_vld_rs1 = |elig;
        issue_fire    = issue_vld_rs1 & issue_gnt_rs1 & ~flush & ~reset;
    end

    // Dealloc strobes, next valid vector and age-matrix update.
    always_comb begin
        e_dealloc = '0;
        if (reset) e_dealloc = '0;
        else if (flush) e_dealloc = valid_q;
        else if (issue_fire) e_dealloc[issue_id_rs1] = 1'b1;
        valid_d = flush ? '0 : ((valid_q & ~e_dealloc) | e_alloc_rs0);
        age_d = age_q;
        if (alloc_fire) begin
            age_d[alloc_id_rs0] = '0;
            for (int j = 0; j < NUM_ENTS; j++) begin
                age_d[j][alloc_id_rs0] = valid_q[j];
            end
        end
    end

    // Occupancy is a popcount of the registered valid vector.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_ENTS; i++) occupancy = occupancy + OW'(valid_q[i]);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTS; i++) age_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_ENTS; i++) age_q[i] <= age_d[i];
        end
    end

`ifdef RS_PICK_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_hang_q, wdog_hang_d;

    // Count cycles with live entries but no grant; saturate at the threshold.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (flush || issue_fire || valid_q == '0) wdog_cnt_d = '0;
        else if (wdog_cnt_q < WW'(WDOG_CYCLES)) wdog_cnt_d = wdog_cnt_q + 1'b1;
        wdog_hang_d = wdog_hang_q | (wdog_cnt_d >= WW'(WDOG_CYCLES));
    end

    // Watchdog registers; the hang flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q  <= '0;
            wdog_hang_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_hang_q <= wdog_hang_d;
        end
    end

    assign wdog_hang = wdog_hang_q;

`ifdef ASSERT
    // Report the first cycle the watchdog fires.
    always @(posedge clk) begin
        if (!reset && wdog_hang_d && !wdog_hang_q) $error("rs_age_picker: watchdog hang");
    end
`endif
`else
    assign wdog_hang = 1'b0;
`endif

`ifndef SYNTHESIS
    // Protocol and structural invariants.
    always @(posedge clk) begin
        if (!reset) begin
            assert (NUM_ENTS >= 2 && NUM_ENTS <= 32 && (NUM_ENTS & (NUM_ENTS - 1)) == 0 && WDOG_CYCLES > 0)
                else $error("rs_age_picker: bad parameters");
            assert ($onehot0(sel)) else $error("rs_age_picker: sel not one-hot");
            assert ((e_alloc_rs0 & valid_q) == '0) else $error("rs_age_picker: alloc into valid entry");
            assert (!(issue_gnt_rs1 && !issue_vld_rs1)) else $error("rs_age_picker: gnt without vld");
            assert (!(alloc_rs0 && !alloc_rdy_rs0)) else $error("rs_age_picker: alloc while full");
            for (int i = 0; i < NUM_ENTS; i++) begin
                for (int j = 0; j < NUM_ENTS; j++) begin
                    if (i != j && valid_q[i] && valid_q[j])
                        assert (age_q[i][j] != age_q[j][i]) else $error("rs_age_picker: age not antisymmetric");
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_age_picker.sv
// Directed self-checking bench for rs_age_picker (8 entries, 2 sources).
module tb_rs_age_picker;
    localparam int N = 8;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_rs0;
    logic          alloc_rdy_rs0;
    logic [2:0]    alloc_id_rs0;
    logic [N-1:0]  e_alloc_rs0;
    logic [N*S-1:0] src_ready_rs1;
    logic          issue_vld_rs1;
    logic [2:0]    issue_id_rs1;
    logic          issue_gnt_rs1;
    logic          flush;
    logic [N-1:0]  e_dealloc;
    logic [3:0]    occupancy;
    logic          wdog_hang;

    int n_checks = 0;
    int n_fail   = 0;

    rs_age_picker #(.NUM_ENTS(N), .NUM_SRCS(S), .WDOG_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .alloc_rs0(alloc_rs0), .alloc_rdy_rs0(alloc_rdy_rs0),
        .alloc_id_rs0(alloc_id_rs0), .e_alloc_rs0(e_alloc_rs0),
        .src_ready_rs1(src_ready_rs1),
        .issue_vld_rs1(issue_vld_rs1), .issue_id_rs1(issue_id_rs1),
        .issue_gnt_rs1(issue_gnt_rs1), .flush(flush),
        .e_dealloc(e_dealloc), .occupancy(occupancy), .wdog_hang(wdog_hang)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; alloc_rs0 = 1'b0; src_ready_rs1 = '0;
        issue_gnt_rs1 = 1'b0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic alloc_n(input int n);
        alloc_rs0 = 1'b1;
        repeat (n) tick();
        alloc_rs0 = 1'b0;
        #1;
    endtask

    task automatic set_ready(input int e);
        src_ready_rs1[e*S +: S] = '1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (alloc_rdy_rs0 !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_rdy got %b exp 1", alloc_rdy_rs0); end
        n_checks++; if (alloc_id_rs0 !== 3'd0) begin n_fail++; $display("FAIL reset_alloc_id got %0d exp 0", alloc_id_rs0); end
        n_checks++; if (e_alloc_rs0 !== 8'h00) begin n_fail++; $display("FAIL reset_e_alloc got %h exp 00", e_alloc_rs0); end
        n_checks++; if (issue_vld_rs1 !== 1'b0) begin n_fail++; $display("FAIL reset_issue_vld got %b exp 0", issue_vld_rs1); end
        n_checks++; if (issue_id_rs1 !== 3'd0) begin n_fail++; $display("FAIL reset_issue_id got %0d exp 0", issue_id_rs1); end
        n_checks++; if (e_dealloc !== 8'h00) begin n_fail++; $display("FAIL reset_e_dealloc got %h exp 00", e_dealloc); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        n_checks++; if (wdog_hang !== 1'b0) begin n_fail++; $display("FAIL reset_wdog got %b exp 0", wdog_hang); end
    endtask

    task automatic test_fill();
        logic [N-1:0] exp_oh;
        do_reset();
        alloc_rs0 = 1'b1;
        for (int i = 0; i < N; i++) begin
            #1;
            exp_oh = 8'h01 << i;
            n_checks++; if (alloc_id_rs0 !== 3'(i)) begin n_fail++; $display("FAIL fill_alloc_id got %0d exp %0d", alloc_id_rs0, i); end
            n_checks++; if (e_alloc_rs0 !== exp_oh) begin n_fail++; $display("FAIL fill_e_alloc got %h exp %h", e_alloc_rs0, exp_oh); end
            tick();
        end
        alloc_rs0 = 1'b0;
        #1;
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_occupancy got %0d exp 8", occupancy); end
        n_checks++; if (alloc_rdy_rs0 !== 1'b0) begin n_fail++; $display("FAIL fill_alloc_rdy got %b exp 0", alloc_rdy_rs0); end
        n_checks++; if (issue_vld_rs1 !== 1'b0) begin n_fail++; $display("FAIL fill_issue_vld got %b exp 0", issue_vld_rs1); end
    endtask

    task automatic test_priority();
        do_reset();
        alloc_n(4);
        set_ready(3); set_ready(1); issue_gnt_rs1 = 1'b1;
        #1;
        n_checks++; if (issue_id_rs1 !== 3'd1) begin n_fail++; $display("FAIL prio_first_id got %0d exp 1", issue_id_rs1); end
        n_checks++; if (e_dealloc !== 8'h02) begin n_fail++; $display("FAIL prio_first_dealloc got %h exp 02", e_dealloc); end
        tick();
        n_checks++; if (issue_id_rs1 !== 3'd3) begin n_fail++; $display("FAIL prio_second_id got %0d exp 3", issue_id_rs1); end
        n_checks++; if (e_dealloc !== 8'h08) begin n_fail++; $display("FAIL prio_second_dealloc got %h exp 08", e_dealloc); end
        tick();
        issue_gnt_rs1 = 1'b0;
        #1;
        n_checks++; if (issue_vld_rs1 !== 1'b0) begin n_fail++; $display("FAIL prio_drained_vld got %b exp 0", issue_vld_rs1); end
        n_checks++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL prio_occupancy got %0d exp 2", occupancy); end
    endtask

    task automatic test_age_order();
        do_reset();
        alloc_n(4);
        set_ready(2); issue_gnt_rs1 = 1'b1;
        #1;
        n_checks++; if (e_dealloc !== 8'h04) begin n_fail++; $display("FAIL age_free2_dealloc got %h exp 04", e_dealloc); end
        tick();
        issue_gnt_rs1 = 1'b0; src_ready_rs1 = '0; alloc_rs0 = 1'b1;
        #1;
        n_checks++; if (alloc_id_rs0 !== 3'd2) begin n_fail++; $display("FAIL age_realloc_id got %0d exp 2", alloc_id_rs0); end
        tick();
        alloc_rs0 = 1'b0;
        set_ready(2); set_ready(3); issue_gnt_rs1 = 1'b1;
        #1;
        n_checks++; if (issue_id_rs1 !== 3'd3) begin n_fail++; $display("FAIL age_older_first got %0d exp 3", issue_id_rs1); end
        n_checks++; if (e_dealloc !== 8'h08) begin n_fail++; $display("FAIL age_older_dealloc got %h exp 08", e_dealloc); end
        tick();
        n_checks++; if (issue_id_rs1 !== 3'd2) begin n_fail++; $display("FAIL age_younger_next got %0d exp 2", issue_id_rs1); end
        tick();
        issue_gnt_rs1 = 1'b0;
        #1;
        n_checks++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL age_occupancy got %0d exp 2", occupancy); end
    endtask

    task automatic test_hold();
        do_reset();
        alloc_n(5);
        set_ready(4);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (issue_vld_rs1 !== 1'b1 || issue_id_rs1 !== 3'd4) begin n_fail++; $display("FAIL hold_issue got vld %b id %0d exp vld 1 id 4", issue_vld_rs1, issue_id_rs1); end
            n_checks++; if (e_dealloc !== 8'h00) begin n_fail++; $display("FAIL hold_no_dealloc got %h exp 00", e_dealloc); end
            n_checks++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL hold_occupancy got %0d exp 5", occupancy); end
            tick();
        end
        issue_gnt_rs1 = 1'b1;
        #1;
        n_checks++; if (e_dealloc !== 8'h10) begin n_fail++; $display("FAIL hold_grant_dealloc got %h exp 10", e_dealloc); end
        tick();
        issue_gnt_rs1 = 1'b0;
        #1;
        n_checks++; if (occupancy !== 4'd4) begin n_fail++; $display("FAIL hold_after_occupancy got %0d exp 4", occupancy); end
        n_checks++; if (issue_vld_rs1 !== 1'b0) begin n_fail++; $display("FAIL hold_after_vld got %b exp 0", issue_vld_rs1); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5);
        flush = 1'b1; alloc_rs0 = 1'b1;
        #1;
        n_checks++; if (e_dealloc !== 8'h1F) begin n_fail++; $display("FAIL flush_dealloc got %h exp 1f", e_dealloc); end
        n_checks++; if (e_alloc_rs0 !== 8'h00) begin n_fail++; $display("FAIL flush_alloc_suppressed got %h exp 00", e_alloc_rs0); end
        tick();
        flush = 1'b0; alloc_rs0 = 1'b0;
        #1;
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_occupancy got %0d exp 0", occupancy); end
        n_checks++; if (alloc_id_rs0 !== 3'd0) begin n_fail++; $display("FAIL flush_alloc_id got %0d exp 0", alloc_id_rs0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_n(2);
        set_ready(0); issue_gnt_rs1 = 1'b1; alloc_rs0 = 1'b1;
        #1;
        n_checks++; if (alloc_id_rs0 !== 3'd2) begin n_fail++; $display("FAIL b2b_alloc_id got %0d exp 2", alloc_id_rs0); end
        n_checks++; if (e_alloc_rs0 !== 8'h04 || e_dealloc !== 8'h01) begin n_fail++; $display("FAIL b2b_strobes got alloc %h dealloc %h exp 04 01", e_alloc_rs0, e_dealloc); end
        tick();
        issue_gnt_rs1 = 1'b0; alloc_rs0 = 1'b0; src_ready_rs1 = '0;
        #1;
        n_checks++; if (occupancy !== 4'd2 || alloc_id_rs0 !== 3'd0) begin n_fail++; $display("FAIL b2b_after got occ %0d id %0d exp 2 0", occupancy, alloc_id_rs0); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc_n(3);
        set_ready(0); issue_gnt_rs1 = 1'b1; reset = 1'b1;
        #1;
        n_checks++; if (e_dealloc !== 8'h00) begin n_fail++; $display("FAIL midreset_dealloc got %h exp 00", e_dealloc); end
        tick();
        reset = 1'b0; issue_gnt_rs1 = 1'b0; src_ready_rs1 = '0;
        #1;
        n_checks++; if (occupancy !== 4'd0 || alloc_rdy_rs0 !== 1'b1) begin n_fail++; $display("FAIL midreset_state got occ %0d rdy %b exp 0 1", occupancy, alloc_rdy_rs0); end
    endtask

    task automatic test_wdog();
        logic exp_hang;
        do_reset();
        alloc_n(1);
        for (int c = 1; c <= 20; c++) begin
            tick();
`ifdef RS_PICK_WDOG_EN
            exp_hang = (c >= 16);
`else
            exp_hang = 1'b0;
`endif
            n_checks++; if (wdog_hang !== exp_hang) begin n_fail++; $display("FAIL wdog_cycle_%0d got %b exp %b", c, wdog_hang, exp_hang); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_priority();
        test_age_order();
        test_hold();
        test_flush();
        test_back_to_back();
        test_mid_reset();
        test_wdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
